// File: rtl/data_memory_sync.sv
// Synchronous RV32I data memory with a fixed wait-state access FSM (IDLE/WAIT/ACK).
// Optional macro DMEM_BOUNDS_CHECK_EN faults addresses outside the array instead of aliasing.
module data_memory_sync #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_mem_req,
    input  logic [XLEN-1:0] i_mem_addr,
    input  logic [XLEN-1:0] i_mem_data,
    input  logic [2:0]      i_funct3,
    input  logic            i_read_write,
    output logic            or_mem_ack,
    output logic [XLEN-1:0] or_mem_data,
    output logic            or_mem_err,
    output logic            or_busy
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_WAIT = 2'd1;
    localparam logic [1:0]  S_ACK  = 2'd2;
    localparam logic [2:0]  WS     = 3'(WAIT_STATES);

    logic [1:0]      state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, wdat_q;
    logic [2:0]      f3_q;
    logic            rw_q;
    logic            ack_q, ack_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    logic [XLEN-1:0] acc_addr_c, acc_data_c, word_c, ld_c, st_data_c;
    logic [2:0]      acc_f3_c;
    logic            acc_rw_c, fault_c, commit_c, cap_c, we_c;
    logic [IDX_W-1:0] idx_c;
    logic [1:0]      off_c;
    logic [7:0]      byte_c;
    logic [15:0]     half_c;
    logic [3:0]      be_c;

    // In IDLE the access is formed from live inputs so a zero-wait access can commit at the capture edge
    assign acc_addr_c = (state_q == S_IDLE) ? i_mem_addr   : addr_q;
    assign acc_data_c = (state_q == S_IDLE) ? i_mem_data   : wdat_q;
    assign acc_f3_c   = (state_q == S_IDLE) ? i_funct3     : f3_q;
    assign acc_rw_c   = (state_q == S_IDLE) ? i_read_write : rw_q;
    assign idx_c      = acc_addr_c[IDX_W+1:2];
    assign off_c      = acc_addr_c[1:0];
    assign word_c     = mem_q[idx_c];

`ifndef DMEM_BOUNDS_CHECK_EN
    logic unused_addr_hi;
    assign unused_addr_hi = |acc_addr_c[XLEN-1:IDX_W+2];
`endif

    // Fault decode, lane selection and load extension
    always_comb begin
        fault_c   = 1'b0;
        ld_c      = '0;
        st_data_c = '0;
        be_c      = 4'b0000;
        byte_c    = word_c[{off_c, 3'b000} +: 8];
        half_c    = off_c[1] ? word_c[31:16] : word_c[15:0];
        if (acc_rw_c) begin
            fault_c = (acc_f3_c > 3'd2) || ((acc_f3_c == 3'd1) && off_c[0])
                   || ((acc_f3_c == 3'd2) && (off_c != 2'd0));
        end else begin
            fault_c = (acc_f3_c == 3'd3) || (acc_f3_c == 3'd6) || (acc_f3_c == 3'd7)
                   || (((acc_f3_c == 3'd1) || (acc_f3_c == 3'd5)) && off_c[0])
                   || ((acc_f3_c == 3'd2) && (off_c != 2'd0));
        end
`ifdef DMEM_BOUNDS_CHECK_EN
        if (|acc_addr_c[XLEN-1:IDX_W+2]) fault_c = 1'b1;
`endif
        case (acc_f3_c)
            3'd0:    ld_c = {{(XLEN-8){byte_c[7]}}, byte_c};
            3'd1:    ld_c = {{(XLEN-16){half_c[15]}}, half_c};
            3'd2:    ld_c = word_c;
            3'd4:    ld_c = {{(XLEN-8){1'b0}}, byte_c};
            3'd5:    ld_c = {{(XLEN-16){1'b0}}, half_c};
            default: ld_c = '0;
        endcase
        case (acc_f3_c)
            3'd0: begin
                st_data_c = {4{acc_data_c[7:0]}};
                be_c      = 4'b0001 << off_c;
            end
            3'd1: begin
                st_data_c = {2{acc_data_c[15:0]}};
                be_c      = off_c[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                st_data_c = acc_data_c;
                be_c      = 4'b1111;
            end
            default: ;
        endcase
    end

    // Next-state logic; commit_c marks the edge that enters ACK
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_c    = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_mem_req) begin
                    cap_c = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d  = S_ACK;
                        commit_c = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d  = S_ACK;
                    cnt_d    = 3'd0;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ack_d   = commit_c;
        err_d   = commit_c && fault_c;
        rdata_d = (commit_c && !fault_c && !acc_rw_c) ? ld_c : '0;
    end

    assign we_c = commit_c && acc_rw_c && !fault_c && i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            wdat_q  <= '0;
            f3_q    <= 3'd0;
            rw_q    <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (cap_c) begin
                addr_q <= i_mem_addr;
                wdat_q <= i_mem_data;
                f3_q   <= i_funct3;
                rw_q   <= i_read_write;
            end
        end
    end

    // Storage array is deliberately not reset
    always_ff @(posedge i_clk) begin
        if (we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) mem_q[idx_c][8*b +: 8] <= st_data_c[8*b +: 8];
            end
        end
    end

    assign or_mem_ack  = ack_q;
    assign or_mem_data = rdata_q;
    assign or_mem_err  = err_q;
    assign or_busy     = (state_q != S_IDLE);

endmodule
